// File: rtl/pipe_pkg.sv
// Shared definitions for the data pipeline and its input buffer.
// Provides the data word width, the word type and the zero bubble value.
package pipe_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    // Value driven into the pipeline whenever no real word is available.
    localparam data_t BUBBLE = '0;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the pipeline input FIFO.
// Ports: i_clk, i_we, i_waddr, i_wdata (sync write); i_raddr -> o_rdata (comb read).
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage holds no reset; validity is tracked by the occupancy count.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipeline_input_fifo.sv
// Elastic valid/ready buffer feeding the three-stage data pipeline.
// Ports: clk, rst; in_data/in_valid/in_ready (producer); out_data/out_valid/
// out_ready (pipeline); count (occupancy); overflow (sticky push-while-full).
module pipeline_input_fifo
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rdata;

    // Flags depend on registered count only, so no input reaches an output
    // combinationally; a full buffer refuses pushes even while popping.
    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? w_rdata : DATA_W'(BUBBLE);
    assign count     = r_count;
    assign overflow  = r_overflow;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_input_fifo.sv
// Directed self-checking bench for pipeline_input_fifo.
// Drives a linear sequence of handshake scenarios and checks outputs.
module tb_pipeline_input_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_input_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_od"}, 32'(out_data), 32'h00);
        chk({tag, "_ir"}, 32'(in_ready), 32'd1);
        chk({tag, "_cnt"}, 32'(count), 32'd0);
    endtask

    logic [7:0] exp_q [$];

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 3; i++) begin
            chk_idle("idle");
            chk("idle_ovf", 32'(overflow), 32'd0);
            tick();
        end

        // Single word, one-cycle latency
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        chk("a5_ov", 32'(out_valid), 32'd1);
        chk("a5_od", 32'(out_data), 32'hA5);
        chk("a5_cnt", 32'(count), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("a5_pop_ov", 32'(out_valid), 32'd0);
        chk("a5_pop_od", 32'(out_data), 32'h00);
        chk("a5_pop_cnt", 32'(count), 32'd0);

        // Fill, overflow, drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 8'(i * 8'h11);
            tick();
            chk("fill_cnt", 32'(count), 32'(i));
        end
        chk("full_ir", 32'(in_ready), 32'd0);
        in_data = 8'h55;
        tick();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(count), 32'd4);
        chk("ovf_head", 32'(out_data), 32'h11);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_ov", 32'(out_valid), 32'd1);
            chk("drain_od", 32'(out_data), 32'(i * 8'h11));
            tick();
        end
        chk_idle("drained");

        // Full with simultaneous pop: no bypass, then push+pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 8'(i * 8'h11);
            tick();
        end
        chk("full2_cnt", 32'(count), 32'd4);
        out_ready = 1'b1;
        in_data   = 8'h66;
        tick();
        chk("nobyp_cnt", 32'(count), 32'd3);
        chk("nobyp_od", 32'(out_data), 32'h22);
        chk("nobyp_ir", 32'(in_ready), 32'd1);
        tick();
        chk("pp_cnt", 32'(count), 32'd3);
        chk("pp_od", 32'(out_data), 32'h33);
        in_valid = 1'b0;
        exp_q = '{8'h33, 8'h44, 8'h66};
        foreach (exp_q[i]) begin
            chk("pp_drain", 32'(out_data), 32'(exp_q[i]));
            tick();
        end
        chk_idle("pp_empty");
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Streaming with pointer wrap
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i);
            tick();
            chk("strm_od", 32'(out_data), 32'(i));
            chk("strm_cnt", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk_idle("strm_end");

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_cnt", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("arst");
        chk("arst_ovf", 32'(overflow), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        in_data  = 8'h7E;
        in_valid = 1'b1;
        tick();
        chk("post_od", 32'(out_data), 32'h7E);
        chk("post_cnt", 32'(count), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_idle("post_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
